mem_port_arbiter: RTL and testbench

- Parametrised arbiter that lets NUM_REQ pipeline requesters share one single-ported memory, e.g. port 0 = data (MEM stage) and port 1 = instruction fetch (IF).
- Uses a valid/ready handshake per requester, registered memory-side outputs, and an in-flight ID pipeline so each read response returns to the requester that issued it.
- Supports fixed-priority or round-robin arbitration, selected by parameter.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Lets NUM_REQ valid/ready requesters share one single-ported
//            memory. Grant is fixed-priority or round-robin (RR_MODE).
//            Memory-side strobes are registered, and an ID pipeline routes
//            each read response back to the requester that issued it.
// Options  : ARB_STATS_EN - per-requester saturating 16-bit stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int RR_MODE = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [NUM_REQ*16-1:0]     stall_cnt
);

    // ID width stays at least one bit so a single-requester build is legal
    localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_id_w-1:0] c_last_id = c_id_w'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_pick;
    logic [NUM_REQ-1:0] w_grant;
    logic [c_id_w-1:0]  w_win_id;
    logic               w_sel_write;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_hs;

    logic [c_id_w-1:0]  r_rr_ptr;
    logic [c_id_w-1:0]  r_issue_id;
    logic [MEM_LAT-1:0] r_pipe_v;
    logic [c_id_w-1:0]  r_pipe_id [MEM_LAT];

    // Grant: lowest set bit at or above the pointer, else lowest set bit overall.
    // In fixed mode the mask is all ones, giving plain lowest-index priority.
    always_comb begin
        w_mask = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (RR_MODE == 0) || (i >= int'(r_rr_ptr));
        end
        w_masked = req_valid & w_mask;
        w_pick   = (|w_masked) ? w_masked : req_valid;
        w_grant  = w_pick & (~w_pick + NUM_REQ'(1));
    end

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;

    // Encode the winner and mux its request fields
    always_comb begin
        w_win_id    = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_id    = c_id_w'(i);
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pointer moves just past the winner on every grant
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= (w_win_id == c_last_id) ? '0 : w_win_id + c_id_w'(1);
        end
    end

    // Register the accepted request onto the memory port; strobes last one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            r_issue_id <= '0;
        end else begin
            mem_read  <= w_hs & ~w_sel_write;
            mem_write <= w_hs & w_sel_write;
            if (w_hs) begin
                mem_addr   <= w_sel_addr;
                mem_wdata  <= w_sel_wdata;
                r_issue_id <= w_win_id;
            end
        end
    end

    // Tag pipeline: entry follows mem_read so the tail lines up with mem_rdata
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pipe_v <= '0;
            for (int s = 0; s < MEM_LAT; s++) begin
                r_pipe_id[s] <= '0;
            end
        end else begin
            r_pipe_v[0]  <= mem_read;
            r_pipe_id[0] <= r_issue_id;
            for (int s = 1; s < MEM_LAT; s++) begin
                r_pipe_v[s]  <= r_pipe_v[s-1];
                r_pipe_id[s] <= r_pipe_id[s-1];
            end
        end
    end

    // Capture returning read data and strobe the owning requester
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else if (r_pipe_v[MEM_LAT-1]) begin
            rsp_valid <= NUM_REQ'(1) << r_pipe_id[MEM_LAT-1];
            rsp_rdata <= mem_rdata;
        end else begin
            rsp_valid <= '0;
        end
    end

`ifdef ARB_STATS_EN
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
            logic [15:0] r_cnt;

            // Count cycles spent waiting, saturating at all ones
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (req_valid[g] && !req_ready[g] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign stall_cnt[g*16 +: 16] = r_cnt;
        end
    endgenerate
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench for mem_port_arbiter: a vector table on a
//            2-port fixed-priority instance, plus hand sequences on a 3-port
//            round-robin instance (MEM_LAT=2) and a 1-port instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // ---------------- fixed priority, NUM_REQ=2, MEM_LAT=1 ----------------
    logic        rst_fix;
    logic [1:0]  f_valid, f_write, f_ready, f_rsp;
    logic [63:0] f_addr, f_wdata;
    logic [31:0] f_rdata, f_maddr, f_mwdata;
    logic [31:0] f_mem_rdata = '0;
    logic        f_mrd, f_mwr;
    logic [31:0] f_stall;

    mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .RR_MODE(0)) u_fix (
        .clock(clock), .reset(rst_fix),
        .req_valid(f_valid), .req_write(f_write), .req_addr(f_addr), .req_wdata(f_wdata),
        .req_ready(f_ready), .rsp_valid(f_rsp), .rsp_rdata(f_rdata),
        .mem_addr(f_maddr), .mem_wdata(f_mwdata), .mem_read(f_mrd), .mem_write(f_mwr),
        .mem_rdata(f_mem_rdata), .stall_cnt(f_stall)
    );

    function automatic logic [31:0] fix_mem(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (32'hCAFE0000 | a);
    endfunction

    // one-cycle memory model
    always @(posedge clock) begin
        if (f_mrd) f_mem_rdata <= fix_mem(f_maddr);
    end

    // ---------------- round robin, NUM_REQ=3, MEM_LAT=2 ----------------
    logic        rst_rr;
    logic [2:0]  r_valid, r_write, r_ready, r_rsp;
    logic [95:0] r_addr, r_wdata;
    logic [31:0] r_rdata, r_maddr, r_mwdata;
    logic [31:0] r_mem_rdata = '0;
    logic [31:0] r_stage = '0;
    logic        r_mrd, r_mwr;
    logic [47:0] r_stall;
    logic [31:0] rr_store [256];
    bit          rr_wr    [256];

    mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .RR_MODE(1)) u_rr (
        .clock(clock), .reset(rst_rr),
        .req_valid(r_valid), .req_write(r_write), .req_addr(r_addr), .req_wdata(r_wdata),
        .req_ready(r_ready), .rsp_valid(r_rsp), .rsp_rdata(r_rdata),
        .mem_addr(r_maddr), .mem_wdata(r_mwdata), .mem_read(r_mrd), .mem_write(r_mwr),
        .mem_rdata(r_mem_rdata), .stall_cnt(r_stall)
    );

    // two-cycle memory model with storage
    always @(posedge clock) begin
        if (r_mwr) begin
            rr_store[r_maddr[9:2]] <= r_mwdata;
            rr_wr[r_maddr[9:2]]    <= 1'b1;
        end
        if (r_mrd) begin
            r_stage <= rr_wr[r_maddr[9:2]] ? rr_store[r_maddr[9:2]]
                                           : (32'hBEEF0000 | {16'h0, r_maddr[15:0]});
        end
        r_mem_rdata <= r_stage;
    end

    // ---------------- single requester ----------------
    logic        rst_one;
    logic [0:0]  o_valid, o_write, o_ready, o_rsp;
    logic [31:0] o_addr, o_wdata, o_rdata, o_maddr, o_mwdata;
    logic [31:0] o_mem_rdata = 32'h0BADF00D;
    logic        o_mrd, o_mwr;
    logic [15:0] o_stall;

    mem_port_arbiter #(.NUM_REQ(1), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .RR_MODE(0)) u_one (
        .clock(clock), .reset(rst_one),
        .req_valid(o_valid), .req_write(o_write), .req_addr(o_addr), .req_wdata(o_wdata),
        .req_ready(o_ready), .rsp_valid(o_rsp), .rsp_rdata(o_rdata),
        .mem_addr(o_maddr), .mem_wdata(o_mwdata), .mem_read(o_mrd), .mem_write(o_mwr),
        .mem_rdata(o_mem_rdata), .stall_cnt(o_stall)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [31:0] a0, a1, wd0, wd1;
        logic [1:0]  ready;
        logic        mrd, mwr;
        logic [31:0] maddr, mwdata;
        logic [1:0]  rsp;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //         valid  write  a0     a1      wd0           wd1           ready  mrd   mwr   maddr  mwdata        rsp    rdata
        tbl[0]  = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 32'h0};
        tbl[1]  = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 32'h0};
        tbl[2]  = '{2'b01, 2'b00, 32'h40, 32'h0,  32'h0,        32'h0,        2'b01, 1'b0, 1'b0, 32'h0,  32'h0,        2'b00, 32'h0};
        tbl[3]  = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'h40, 32'h0,        2'b00, 32'h0};
        tbl[4]  = '{2'b11, 2'b00, 32'h44, 32'h100, 32'h0,       32'h0,        2'b01, 1'b0, 1'b0, 32'h40, 32'h0,        2'b00, 32'h0};
        tbl[5]  = '{2'b10, 2'b00, 32'h0, 32'h100, 32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 32'h44, 32'h0,        2'b01, 32'hDEADBEEF};
        tbl[6]  = '{2'b01, 2'b01, 32'h48, 32'h0,  32'h11112222, 32'h0,        2'b01, 1'b1, 1'b0, 32'h100, 32'h0,       2'b00, 32'hDEADBEEF};
        tbl[7]  = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b0, 1'b1, 32'h48, 32'h11112222, 2'b01, 32'hCAFE0044};
        tbl[8]  = '{2'b10, 2'b10, 32'h0, 32'h4C,  32'h0,        32'h33334444, 2'b10, 1'b0, 1'b0, 32'h48, 32'h11112222, 2'b10, 32'hCAFE0100};
        tbl[9]  = '{2'b11, 2'b00, 32'h50, 32'h54, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 32'h4C, 32'h33334444, 2'b00, 32'hCAFE0100};
        tbl[10] = '{2'b11, 2'b00, 32'h58, 32'h54, 32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 32'h50, 32'h0,        2'b00, 32'hCAFE0100};
        tbl[11] = '{2'b10, 2'b00, 32'h0, 32'h54,  32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 32'h58, 32'h0,        2'b00, 32'hCAFE0100};
        tbl[12] = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'h54, 32'h0,        2'b01, 32'hCAFE0050};
        tbl[13] = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 32'h54, 32'h0,        2'b01, 32'hCAFE0058};
        tbl[14] = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 32'h54, 32'h0,        2'b10, 32'hCAFE0054};
        tbl[15] = '{2'b00, 2'b00, 32'h0, 32'h0,   32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 32'h54, 32'h0,        2'b00, 32'hCAFE0054};

        f_valid = '0; f_write = '0; f_addr = '0; f_wdata = '0;
        r_valid = '0; r_write = '0; r_addr = '0; r_wdata = '0;
        o_valid = '0; o_write = '0; o_addr = '0; o_wdata = '0;
        rst_fix = 1'b1; rst_rr = 1'b1; rst_one = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        rst_fix = 1'b0; rst_one = 1'b0;

        // ---------- vector table on the fixed-priority instance ----------
        for (int i = 0; i < 16; i++) begin
            f_valid = tbl[i].valid;
            f_write = tbl[i].write;
            f_addr  = {tbl[i].a1, tbl[i].a0};
            f_wdata = {tbl[i].wd1, tbl[i].wd0};
            #1;
            chk($sformatf("v%0d ready", i),     f_ready,  tbl[i].ready);
            chk($sformatf("v%0d mem_read", i),  f_mrd,    tbl[i].mrd);
            chk($sformatf("v%0d mem_write", i), f_mwr,    tbl[i].mwr);
            chk($sformatf("v%0d mem_addr", i),  f_maddr,  tbl[i].maddr);
            chk($sformatf("v%0d mem_wdata", i), f_mwdata, tbl[i].mwdata);
            chk($sformatf("v%0d rsp_valid", i), f_rsp,    tbl[i].rsp);
            chk($sformatf("v%0d rsp_rdata", i), f_rdata,  tbl[i].rdata);
            step();
        end

        // ---------- reset with a read in flight ----------
        f_valid = 2'b01; f_write = '0; f_addr = {32'h0, 32'h60}; f_wdata = '0;
        #1;
        chk("inflight ready", f_ready, 2'b01);
        step();
        f_valid = '0;
        #1;
        chk("inflight mem_read", f_mrd, 1'b1);
        rst_fix = 1'b1;
        #1;
        chk("async rst mem_read", f_mrd, 1'b0);
        chk("async rst mem_addr", f_maddr, 32'h0);
        chk("async rst rsp_rdata", f_rdata, 32'h0);
        chk("async rst rsp_valid", f_rsp, 2'b00);
        step();
        rst_fix = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("dropped rsp c%0d", k), f_rsp, 2'b00);
            step();
        end
        begin
            int lat;
            lat = -1;
            f_valid = 2'b01; f_addr = {32'h0, 32'h64};
            #1;
            chk("post-rst ready", f_ready, 2'b01);
            for (int k = 1; k <= 10; k++) begin
                @(posedge clock);
                #1;
                f_valid = '0;
                #1;
                if (f_rsp != 2'b00) begin
                    lat = k;
                    break;
                end
            end
            chk("post-rst latency", lat, 3);
            chk("post-rst rsp_valid", f_rsp, 2'b01);
            chk("post-rst rdata", f_rdata, 32'hCAFE0064);
            step();
        end

        // ---------- stall counters ----------
        #1;
        chk("stall0 initial", f_stall[15:0], 16'h0);
        chk("stall1 initial", f_stall[31:16], 16'h0);
        f_valid = 2'b11; f_write = '0; f_addr = {32'h74, 32'h70};
        repeat (5) step();
        chk("stall1 after 5", f_stall[31:16], STATS_ON ? 16'd5 : 16'd0);
        chk("stall0 after 5", f_stall[15:0], 16'h0);
        repeat (70000) @(posedge clock);
        #1;
        chk("stall1 saturated", f_stall[31:16], STATS_ON ? 16'hFFFF : 16'h0);
        chk("stall0 still zero", f_stall[15:0], 16'h0);
        f_valid = '0;
        step();

        // ---------- round robin: write then read, MEM_LAT=2 ----------
        rst_rr = 1'b0;
        step(); step();                          // cycles 0,1 idle
        r_valid = 3'b010; r_write = 3'b010;      // cycle 2: write
        r_addr = {32'h0, 32'h80, 32'h0}; r_wdata = {32'h0, 32'h1234, 32'h0};
        #1;
        chk("wr ready", r_ready, 3'b010);
        step();
        r_write = 3'b000;                        // cycle 3: read same address
        #1;
        chk("rd ready", r_ready, 3'b010);
        chk("c3 mem_write", r_mwr, 1'b1);
        chk("c3 mem_read", r_mrd, 1'b0);
        chk("c3 mem_addr", r_maddr, 32'h80);
        chk("c3 mem_wdata", r_mwdata, 32'h1234);
        step();
        r_valid = '0;                            // cycle 4
        #1;
        chk("c4 mem_read", r_mrd, 1'b1);
        chk("c4 mem_write", r_mwr, 1'b0);
        chk("c4 mem_addr", r_maddr, 32'h80);
        for (int c = 4; c <= 6; c++) begin
            chk($sformatf("c%0d no rsp", c), r_rsp, 3'b000);
            step();
            #1;
        end
        chk("c7 rsp_valid", r_rsp, 3'b010);
        chk("c7 rsp_rdata", r_rdata, 32'h1234);
        step();
        #1;
        chk("c8 rsp_valid", r_rsp, 3'b000);
        chk("c8 rdata hold", r_rdata, 32'h1234);
        // pointer now sits at 2: search wraps to requester 0
        r_valid = 3'b011; r_addr = {32'h0, 32'h24, 32'h20};
        #1;
        chk("rr wrap grant", r_ready, 3'b001);
        step();
        r_valid = 3'b010;
        #1;
        chk("rr ptr1 grant", r_ready, 3'b010);
        step();
        r_valid = '0;
        rst_rr = 1'b1;
        #1;
        chk("rr reset rsp", r_rsp, 3'b000);
        chk("rr reset stall", r_stall, 48'h0);
        step();
        rst_rr = 1'b0;

        // ---------- round robin: all three valid, grants 0,1,2,0,1,2 ----------
        r_addr = {32'h18, 32'h14, 32'h10}; r_write = '0;
        for (int i = 0; i < 10; i++) begin
            logic [2:0]  e_ready, e_rsp;
            logic [31:0] e_rdata;
            r_valid = (i < 6) ? 3'b111 : 3'b000;
            e_ready = (i < 6) ? (3'b001 << (i % 3)) : 3'b000;
            e_rsp   = (i >= 4) ? (3'b001 << ((i - 4) % 3)) : 3'b000;
            e_rdata = (i >= 4) ? (32'hBEEF0010 + 32'(4 * ((i - 4) % 3))) : 32'h0;
            #1;
            chk($sformatf("rr%0d ready", i), r_ready, e_ready);
            chk($sformatf("rr%0d rsp", i),   r_rsp,   e_rsp);
            chk($sformatf("rr%0d rdata", i), r_rdata, e_rdata);
            step();
        end

        // ---------- single requester ----------
        o_valid = 1'b0;
        #1;
        chk("one ready idle", o_ready, 1'b0);
        o_valid = 1'b1; o_addr = 32'h7; o_wdata = 32'h55;
        #1;
        chk("one ready", o_ready, 1'b1);
        step();
        o_valid = 1'b0;
        #1;
        chk("one mem_read", o_mrd, 1'b1);
        chk("one mem_write", o_mwr, 1'b0);
        chk("one mem_addr", o_maddr, 32'h7);
        chk("one mem_wdata", o_mwdata, 32'h55);
        step(); step();
        #1;
        chk("one rsp_valid", o_rsp, 1'b1);
        chk("one rsp_rdata", o_rdata, 32'h0BADF00D);
        chk("one stall", o_stall, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
